// File: rtl/echo_delay.sv
// echo_delay: stereo echo/delay with programmable length, wet mix, feedback and bypass.
// Define ECHO_DELAY_SATURATE_EN to clamp results; otherwise results wrap.
module echo_delay #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int GAIN_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] audio_left_in,
    input  logic [DATA_WIDTH-1:0] audio_right_in,
    input  logic [ADDR_WIDTH-1:0] delay_len,
    input  logic [GAIN_WIDTH-1:0] mix_gain,
    input  logic [GAIN_WIDTH-1:0] fb_gain,
    input  logic                  bypass,
    output logic [DATA_WIDTH-1:0] audio_left_out,
    output logic [DATA_WIDTH-1:0] audio_right_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  dropped
);
    localparam int W = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] FILL_MAX = '1;
    localparam logic signed [W-1:0] MAXV = W'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [W-1:0] MINV = -MAXV - W'(1);

    typedef enum logic [1:0] {IDLE, RD, CALC, WR} state_t;

    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, fill_q, fill_d, dly_q, dly_d;
    logic [GAIN_WIDTH-1:0] mg_q, mg_d, fg_q, fg_d;
    logic signed [DATA_WIDTH-1:0] xl_q, xl_d, xr_q, xr_d;
    logic [DATA_WIDTH-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
    logic byp_q, byp_d, out_valid_q, out_valid_d, dropped_q, dropped_d;
    logic [2*DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [2*DATA_WIDTH-1:0] rd_q, wdata;
    logic [ADDR_WIDTH-1:0] addr;
    logic we, use_d;
    logic [DATA_WIDTH-1:0] o_l, o_r, st_l, st_r;

    function automatic logic [DATA_WIDTH-1:0] reduce(input logic signed [W-1:0] v);
`ifdef ECHO_DELAY_SATURATE_EN
        return v > MAXV ? MAXV[DATA_WIDTH-1:0] : v < MINV ? MINV[DATA_WIDTH-1:0] : v[DATA_WIDTH-1:0];
`else
        return DATA_WIDTH'(v);
`endif
    endfunction

    // Returns {out, stored} for one channel.
    function automatic logic [2*DATA_WIDTH-1:0] chan(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic signed [DATA_WIDTH-1:0] d,
        input logic [GAIN_WIDTH-1:0] mg,
        input logic [GAIN_WIDTH-1:0] fg,
        input logic byp
    );
        logic signed [W-1:0] wet, fbk;
        wet = (W'(d) * W'($signed({1'b0, mg}))) >>> GAIN_WIDTH;
        fbk = (W'(d) * W'($signed({1'b0, fg}))) >>> GAIN_WIDTH;
        return {reduce(byp ? W'(x) : W'(x) + wet), reduce(W'(x) + fbk)};
    endfunction

    assign addr  = (state_q == WR) ? wr_ptr_q : wr_ptr_q - dly_q;
    assign we    = (state_q == WR) && rst_n;
    // Unwritten slots since reset must never feed the echo.
    assign use_d = (dly_q != '0) && (fill_q >= dly_q);
    assign {o_l, st_l} = chan(xl_q, use_d ? rd_q[2*DATA_WIDTH-1:DATA_WIDTH] : '0, mg_q, fg_q, byp_q);
    assign {o_r, st_r} = chan(xr_q, use_d ? rd_q[DATA_WIDTH-1:0] : '0, mg_q, fg_q, byp_q);
    assign wdata = {st_l, st_r};

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rd_q <= mem[addr];
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        dly_d       = dly_q;
        mg_d        = mg_q;
        fg_d        = fg_q;
        xl_d        = xl_q;
        xr_d        = xr_q;
        byp_d       = byp_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        out_valid_d = 1'b0;
        dropped_d   = dropped_q | (sample_valid && state_q != IDLE);
        case (state_q)
            IDLE: if (sample_valid) begin
                xl_d    = audio_left_in;
                xr_d    = audio_right_in;
                dly_d   = delay_len;
                mg_d    = mix_gain;
                fg_d    = fb_gain;
                byp_d   = bypass;
                state_d = RD;
            end
            RD:   state_d = CALC;
            CALC: state_d = WR;
            WR: begin
                out_l_d     = o_l;
                out_r_d     = o_r;
                out_valid_d = 1'b1;
                wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(1);
                fill_d      = (fill_q == FILL_MAX) ? fill_q : fill_q + ADDR_WIDTH'(1);
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            dly_q       <= '0;
            mg_q        <= '0;
            fg_q        <= '0;
            xl_q        <= '0;
            xr_q        <= '0;
            byp_q       <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            dly_q       <= dly_d;
            mg_q        <= mg_d;
            fg_q        <= fg_d;
            xl_q        <= xl_d;
            xr_q        <= xr_d;
            byp_q       <= byp_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            dropped_q   <= dropped_d;
        end
    end

    assign audio_left_out  = out_l_q;
    assign audio_right_out = out_r_q;
    assign out_valid       = out_valid_q;
    assign busy            = state_q != IDLE;
    assign dropped         = dropped_q;
endmodule

// File: doc/echo_delay.md
Name: echo_delay

Overview:
- Stereo echo/delay for the audio codec path; successor to the fixed one-sample delay adder.
- Adds a runtime-programmable delay length, a wet-mix gain, feedback (recirculating echo) and a bypass path.
- Uses a per-channel circular sample buffer in single-port inferred RAM, driven by a multi-cycle per-sample FSM.
- Sits between the codec receive path and the codec transmit path, clocked by the system clock with a one-cycle sample strobe.

Parameters:
- DATA_WIDTH, 16, sample width; signed two's complement.
- ADDR_WIDTH, 10, buffer address width; depth = 2**ADDR_WIDTH samples per channel.
- GAIN_WIDTH, 8, unsigned fractional gain width; gain value g means g / 2**GAIN_WIDTH.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- sample_valid  input  1  one-cycle strobe: new sample pair present on the audio inputs.
- audio_left_in  input  DATA_WIDTH  left sample, signed.
- audio_right_in  input  DATA_WIDTH  right sample, signed.
- delay_len  input  ADDR_WIDTH  echo delay in samples; 0 = no echo.
- mix_gain  input  GAIN_WIDTH  wet gain applied to the delayed sample at the output.
- fb_gain  input  GAIN_WIDTH  feedback gain applied to the delayed sample written back to the buffer.
- bypass  input  1  1 = output equals input; buffer still updated.
- audio_left_out  output  DATA_WIDTH  processed left sample, registered.
- audio_right_out  output  DATA_WIDTH  processed right sample, registered.
- out_valid  output  1  one-cycle strobe: outputs updated.
- busy  output  1  FSM not in IDLE.
- dropped  output  1  sticky; set when sample_valid arrives while busy; cleared only by reset.

Behaviour:
- Reset (rst_n=0 at posedge): FSM to IDLE. wr_ptr=0, fill count=0. audio_*_out=0, out_valid=0, busy=0, dropped=0. RAM contents are not cleared.
- FSM: IDLE -> RD -> CALC -> WR -> IDLE.
  - IDLE: on sample_valid, latch both inputs, delay_len, mix_gain, fb_gain and bypass.
  - RD: RAM read address = wr_ptr - delay_len, modulo depth, wrapping naturally.
  - CALC: RAM data valid; compute results.
  - WR: write both channels at wr_ptr; register outputs; pulse out_valid; advance wr_ptr by 1 with wrap; increment fill count, saturating at depth-1.
- Latency: out_valid rises exactly 4 cycles after the cycle in which sample_valid is high. The minimum sample spacing is 4 cycles.
- sample_valid while busy: sample ignored; dropped set; the in-flight sample completes unaffected.
- Delayed term d: forced to 0 when delay_len=0 or when fill count < delay_len. This prevents reading unwritten RAM after reset.
- Arithmetic per channel, with x = latched input:
  - wet = (d * mix_gain) >>> GAIN_WIDTH, arithmetic shift, truncating toward minus infinity.
  - fbk = (d * fb_gain) >>> GAIN_WIDTH.
  - out = x + wet; stored = x + fbk.
  - Intermediates are DATA_WIDTH+GAIN_WIDTH+1 bits; the final result is reduced to DATA_WIDTH per the Optional Feature.
- Bypass: out = x. The buffer still stores x + fbk, so the echo tail is preserved when bypass is released.
- delay_len or gain changes between samples take effect on the next accepted sample; mid-sample changes are ignored because the values are latched.
- Reset asserted mid-sample: the sample is aborted, no write occurs, and out_valid stays 0.
- Outputs hold their value between out_valid pulses.

Optional Feature:
- Macro: ECHO_DELAY_SATURATE_EN.
- Defined: out and stored results are clamped to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1].
- Not defined: results wrap, i.e. the low DATA_WIDTH bits are kept, with two's-complement overflow.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then 1; no sample_valid -> outputs 0, out_valid 0, busy 0, dropped 0.
- Basic echo: delay_len=4, mix_gain=128, fb_gain=0; left impulse 1000 then zeros, one sample every 8 cycles -> out 1000, 0, 0, 0, 500, 0...; each out_valid arrives 4 cycles after its strobe.
- Feedback decay: delay_len=2, mix_gain=255, fb_gain=128; impulse 4096 -> outputs 4096, 0, 4080, 0, 2040, 0, 1020 ...
- Wrap-around: ADDR_WIDTH=4, delay_len=15; send 40 ramp samples 1..40 with mix_gain=255, fb_gain=0 -> sample n>=16 outputs n + (((n-15)*255)>>>8).
- Overflow: inputs 30000; delayed 30000; mix_gain=255 -> with ECHO_DELAY_SATURATE_EN out=32767; without, out is the 16-bit wrapped value.
- Drop/reset: sample_valid on consecutive cycles -> second ignored, dropped=1. Reset during CALC -> no out_valid; fill count 0, so a following sample with delay_len=1 gets d=0.
